// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// state encodings, opcodes, datapath select codes and small decode helpers.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] BR_EQ  = 2'b00;
    localparam logic [1:0] BR_NE  = 2'b01;
    localparam logic [1:0] BR_GTZ = 2'b10;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic [1:0] access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_SB: return SIZE_BYTE;
            OP_LH, OP_SH: return SIZE_HALF;
            default:      return SIZE_WORD;
        endcase
    endfunction

    function automatic logic [1:0] branch_kind(input logic [5:0] op);
        case (op)
            OP_BNE:  return BR_NE;
            OP_BGTZ: return BR_GTZ;
            default: return BR_EQ;
        endcase
    endfunction

    // States that stall on the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller bundle: instruction/handshake inputs and all datapath controls.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32
);
    logic [INSTR_W-1:0] instr;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         branch_type;
    logic [1:0]         pc_src;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         mem_size;
    logic               ir_write;
    logic [1:0]         reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               trap;
    logic               instr_done;
    logic [3:0]         state_o;

    modport master (
        input  instr, mem_ready,
        output pc_write, pc_write_cond, branch_type, pc_src, iord, mem_read,
               mem_write, mem_size, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, trap, instr_done, state_o
    );

    modport slave (
        output instr, mem_ready,
        input  pc_write, pc_write_cond, branch_type, pc_src, iord, mem_read,
               mem_write, mem_size, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, trap, instr_done, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl_wait_timer.sv
// Counts stalled cycles in a memory-wait state; flags a timeout when the
// count hits the limit while memory is still not ready.
module mips_ctrl_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_waiting,
    output logic o_timeout
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

    logic [7:0] r_cnt;

    // Stall counter: cleared on every state entry, saturates at 8'hFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_waiting && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_timeout = i_waiting && (r_cnt == LIMIT);
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction and decodes all
// datapath enables/selects from the registered state (plus mem_ready).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT_CYC = 15,
    parameter int TRAP_EN     = 1
) (
    input logic                   clk,
    input logic                   rst,
    mips_multicycle_ctrl_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op;
    logic       w_ready;
    logic       w_timeout;
    logic       w_to_trap;
    logic       w_unused_bits;

    assign w_op          = bus.instr[INSTR_W-1 -: 6];
    assign w_unused_bits = ^bus.instr[INSTR_W-7:0];
    assign w_ready       = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
    assign w_to_trap     = (TRAP_EN != 0) && (MEM_WAIT_EN != 0) && w_timeout;
    assign bus.state_o   = r_state;

    mips_ctrl_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_next != r_state),
        .i_waiting (is_wait_state(r_state) && !w_ready),
        .o_timeout (w_timeout)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next            = r_state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_type   = BR_EQ;
        bus.pc_src        = PC_SRC_ALU;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_size      = SIZE_WORD;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = REG_DST_RT;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALU_ADD;
        bus.trap          = 1'b0;
        bus.instr_done    = 1'b0;

        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = w_ready;
                bus.pc_write  = w_ready;
                if (w_ready) begin
                    w_next = S_DECODE;
                end else if (w_to_trap) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
                case (w_op)
                    OP_LW, OP_LB, OP_LH, OP_SW, OP_SB, OP_SH: w_next = S_MEM_ADDR;
                    OP_RTYPE:                           w_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  w_next = S_EXEC_I;
                    OP_BEQ, OP_BNE, OP_BGTZ:            w_next = S_BRANCH;
                    OP_J, OP_JAL:                       w_next = S_JUMP;
                    default: begin
                        // Without traps an unknown opcode retires as a NOP here.
                        if (TRAP_EN != 0) begin
                            w_next = S_TRAP;
                        end else begin
                            w_next         = S_FETCH;
                            bus.instr_done = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                if (is_load(w_op)) begin
                    w_next = S_MEM_RD;
                end else begin
                    w_next = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                bus.mem_size = access_size(w_op);
                if (w_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_to_trap) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.mem_size   = access_size(w_op);
                bus.instr_done = w_ready;
                if (w_ready) begin
                    w_next = S_FETCH;
                end else if (w_to_trap) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_MEM_WR;
                end
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
                w_next        = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = REG_DST_RD;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_IMM;
                w_next        = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = PC_SRC_ALUOUT;
                bus.branch_type   = branch_kind(w_op);
                bus.instr_done    = 1'b1;
                w_next            = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = PC_SRC_JUMP;
                bus.instr_done = 1'b1;
                if (w_op == OP_JAL) begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = REG_DST_R31;
                end else begin
                    bus.reg_write = 1'b0;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                bus.trap     = 1'b1;
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_SRC_TRAP;
                w_next       = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: stimulus pushes per-cycle expectations, a negedge monitor
// compares two controllers (traps on / traps off) against them.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] branch_type;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       trap;
        logic       instr_done;
    } outs_t;

    typedef struct {
        logic [3:0] st0;
        logic [3:0] st1;
        bit         chk1;
        logic [5:0] op;
        bit         rdy;
        string      nm;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    exp_t  q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic [5:0] cur_op = 6'd0;
    outs_t a0, a1;

    mips_multicycle_ctrl_if #(.INSTR_W(32)) bus0 ();
    mips_multicycle_ctrl_if #(.INSTR_W(32)) bus1 ();

    mips_multicycle_ctrl #(.INSTR_W(32), .MEM_WAIT_EN(1), .TIMEOUT_CYC(15), .TRAP_EN(1))
        u_dut (.clk(clk), .rst(rst), .bus(bus0));
    mips_multicycle_ctrl #(.INSTR_W(32), .MEM_WAIT_EN(1), .TIMEOUT_CYC(15), .TRAP_EN(0))
        u_dut_nt (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    assign a0 = {bus0.pc_write, bus0.pc_write_cond, bus0.branch_type, bus0.pc_src,
                 bus0.iord, bus0.mem_read, bus0.mem_write, bus0.mem_size, bus0.ir_write,
                 bus0.reg_dst, bus0.mem_to_reg, bus0.reg_write, bus0.alu_src_a,
                 bus0.alu_src_b, bus0.alu_op, bus0.trap, bus0.instr_done};
    assign a1 = {bus1.pc_write, bus1.pc_write_cond, bus1.branch_type, bus1.pc_src,
                 bus1.iord, bus1.mem_read, bus1.mem_write, bus1.mem_size, bus1.ir_write,
                 bus1.reg_dst, bus1.mem_to_reg, bus1.reg_write, bus1.alu_src_a,
                 bus1.alu_src_b, bus1.alu_op, bus1.trap, bus1.instr_done};

    function automatic bit legal(input logic [5:0] op);
        case (op)
            6'h23, 6'h20, 6'h21, 6'h2B, 6'h28, 6'h29, 6'h08, 6'h0C,
            6'h0D, 6'h0A, 6'h00, 6'h04, 6'h05, 6'h07, 6'h02, 6'h03: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] size_of(input logic [5:0] op);
        if (op == 6'h20 || op == 6'h28) return 2'b00;
        if (op == 6'h21 || op == 6'h29) return 2'b01;
        return 2'b10;
    endfunction

    // Expected outputs straight from the per-state output table.
    function automatic outs_t spec_out(input logic [3:0] st, input logic [5:0] op,
                                       input bit rdy, input bit trap_en);
        outs_t o;
        o = '0;
        o.mem_size = 2'b10;
        case (st)
            4'd0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            4'd1:  begin o.alu_src_b = 2'b11; o.instr_done = !trap_en && !legal(op); end
            4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            4'd3:  begin o.mem_read = 1'b1; o.iord = 1'b1; o.mem_size = size_of(op); end
            4'd4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; end
            4'd5:  begin o.mem_write = 1'b1; o.iord = 1'b1; o.mem_size = size_of(op); o.instr_done = rdy; end
            4'd6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            4'd7:  begin o.reg_write = 1'b1; o.reg_dst = 2'b01; o.instr_done = 1'b1; end
            4'd8:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
            4'd9:  begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
            4'd10: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1; o.pc_src = 2'b01;
                o.instr_done = 1'b1;
                o.branch_type = (op == 6'h05) ? 2'b01 : ((op == 6'h07) ? 2'b10 : 2'b00);
            end
            4'd11: begin
                o.pc_write = 1'b1; o.pc_src = 2'b10; o.instr_done = 1'b1;
                if (op == 6'h03) begin o.reg_write = 1'b1; o.reg_dst = 2'b10; end
            end
            4'd12: begin o.trap = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'b11; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        exp_t  e;
        outs_t x;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_checks++;
            if (bus0.state_o !== e.st0) begin
                n_fail++;
                $display("FAIL %s dut0 state: got %0d expected %0d", e.nm, bus0.state_o, e.st0);
            end
            x = spec_out(e.st0, e.op, e.rdy, 1'b1);
            n_checks++;
            if (a0 !== x) begin
                n_fail++;
                $display("FAIL %s dut0 outputs: got %h expected %h", e.nm, a0, x);
            end
            if (e.chk1) begin
                n_checks++;
                if (bus1.state_o !== e.st1) begin
                    n_fail++;
                    $display("FAIL %s dut_nt state: got %0d expected %0d", e.nm, bus1.state_o, e.st1);
                end
                x = spec_out(e.st1, e.op, e.rdy, 1'b0);
                n_checks++;
                if (a1 !== x) begin
                    n_fail++;
                    $display("FAIL %s dut_nt outputs: got %h expected %h", e.nm, a1, x);
                end
            end
        end
    end

    task automatic set_instr(input logic [31:0] v);
        bus0.instr = v;
        bus1.instr = v;
        cur_op     = v[31:26];
    endtask

    task automatic cyc2(input logic [3:0] s0, input logic [3:0] s1, input bit c1,
                        input bit rdy, input string nm);
        exp_t e;
        bus0.mem_ready = rdy;
        bus1.mem_ready = rdy;
        e.st0 = s0; e.st1 = s1; e.chk1 = c1; e.op = cur_op; e.rdy = rdy; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [3:0] s, input bit rdy, input string nm);
        cyc2(s, s, 1'b1, rdy, nm);
    endtask

    initial begin
        set_instr(32'h8C820004);
        bus0.mem_ready = 1'b1;
        bus1.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc(4'd0, 1'b1, "reset_rdy");
        cyc(4'd0, 1'b0, "reset_nrdy");
        rst = 1'b1;

        // lw, no wait states: 0,1,2,3,4
        cyc(4'd0, 1'b1, "lw_fetch"); cyc(4'd1, 1'b1, "lw_decode"); cyc(4'd2, 1'b1, "lw_addr");
        cyc(4'd3, 1'b1, "lw_rd");    cyc(4'd4, 1'b1, "lw_wb");

        // lh with one wait state in MEM_RD
        set_instr(32'h84820002);
        cyc(4'd0, 1'b1, "lh_fetch"); cyc(4'd1, 1'b1, "lh_decode"); cyc(4'd2, 1'b1, "lh_addr");
        cyc(4'd3, 1'b0, "lh_rd_wait"); cyc(4'd3, 1'b1, "lh_rd"); cyc(4'd4, 1'b1, "lh_wb");

        // sb with three wait states in MEM_WR
        set_instr(32'hA0A20000);
        cyc(4'd0, 1'b1, "sb_fetch"); cyc(4'd1, 1'b1, "sb_decode"); cyc(4'd2, 1'b1, "sb_addr");
        for (int i = 0; i < 3; i++) cyc(4'd5, 1'b0, "sb_wr_wait");
        cyc(4'd5, 1'b1, "sb_wr_done");

        set_instr(32'h10220003);
        cyc(4'd0, 1'b1, "beq_fetch"); cyc(4'd1, 1'b1, "beq_decode"); cyc(4'd10, 1'b1, "beq_branch");
        set_instr(32'h1C200002);
        cyc(4'd0, 1'b1, "bgtz_fetch"); cyc(4'd1, 1'b1, "bgtz_decode"); cyc(4'd10, 1'b1, "bgtz_branch");
        set_instr(32'h0C000010);
        cyc(4'd0, 1'b1, "jal_fetch"); cyc(4'd1, 1'b1, "jal_decode"); cyc(4'd11, 1'b1, "jal_jump");
        set_instr(32'h08000010);
        cyc(4'd0, 1'b1, "j_fetch"); cyc(4'd1, 1'b1, "j_decode"); cyc(4'd11, 1'b1, "j_jump");
        set_instr(32'h20010005);
        cyc(4'd0, 1'b1, "addi_fetch"); cyc(4'd1, 1'b1, "addi_decode");
        cyc(4'd8, 1'b1, "addi_exec");  cyc(4'd9, 1'b1, "addi_wb");

        // Illegal opcode: trap on dut0, NOP retire on dut_nt (held in FETCH by ready=0)
        set_instr(32'hFC000000);
        cyc(4'd0, 1'b1, "ill_fetch"); cyc(4'd1, 1'b1, "ill_decode");
        cyc2(4'd12, 4'd0, 1'b1, 1'b0, "ill_trap");

        // Ready arrives exactly at the timeout limit: access completes
        set_instr(32'h00221820);
        for (int i = 0; i < 15; i++) cyc(4'd0, 1'b0, "rw_wait");
        cyc(4'd0, 1'b1, "rw_limit_ready");
        cyc(4'd1, 1'b1, "rw_decode"); cyc(4'd6, 1'b1, "r_exec"); cyc(4'd7, 1'b1, "r_wb");

        // Fetch timeout: 16 stalled cycles then TRAP (dut_nt never times out)
        set_instr(32'h20010005);
        for (int i = 0; i < 16; i++) cyc(4'd0, 1'b0, "to_wait");
        cyc2(4'd12, 4'd0, 1'b1, 1'b0, "to_trap");
        cyc(4'd0, 1'b1, "to_fetch"); cyc(4'd1, 1'b1, "to_decode");
        cyc(4'd8, 1'b1, "to_exec");  cyc(4'd9, 1'b1, "to_wb");

        // Reset asserted while sw stalls in MEM_WR
        set_instr(32'hAC820000);
        cyc(4'd0, 1'b1, "sw_fetch"); cyc(4'd1, 1'b1, "sw_decode"); cyc(4'd2, 1'b1, "sw_addr");
        cyc(4'd5, 1'b0, "sw_wr_wait");
        rst = 1'b0;
        cyc(4'd0, 1'b0, "rst_mid_wr");
        cyc(4'd0, 1'b1, "rst_hold");
        rst = 1'b1;
        cyc(4'd0, 1'b1, "post_fetch"); cyc(4'd1, 1'b1, "post_decode"); cyc(4'd2, 1'b1, "post_addr");

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Parametrised multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives all datapath enables and mux selects.
It extends the existing controller with:
- memory wait-state handshake (mem_ready) and a wait timeout;
- byte/half/word access size;
- jal link writeback;
- an illegal-opcode trap;
- an instruction-retired pulse.
It sits between the instruction register and the datapath / memory interface.

Parameters:
INSTR_W, 32, instruction width; opcode is instr[INSTR_W-1:INSTR_W-6]
MEM_WAIT_EN, 1, 1 = FETCH/MEM_RD/MEM_WR hold until mem_ready; 0 = mem_ready ignored (treated as 1)
TIMEOUT_CYC, 15, max wait cycles before trap (range 1..255); the timeout is disabled when MEM_WAIT_EN=0
TRAP_EN, 1, 1 = illegal opcode/timeout enters TRAP; 0 = illegal opcode retires as NOP, timeout disabled

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  INSTR_W  current instruction register contents
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition true
branch_type  out  2  00 beq, 01 bne, 10 bgtz
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector
iord  out  1  memory address from ALUOut (1) or PC (0)
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_size  out  2  00 byte, 01 half, 10 word
ir_write  out  1  load instruction register
reg_dst  out  2  00 rt, 01 rd, 10 r31
mem_to_reg  out  1  writeback from memory data
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct, 11 immediate opcode
trap  out  1  one-cycle trap pulse
instr_done  out  1  one-cycle pulse in the final state of each instruction
state_o  out  4  current state encoding

Behaviour:
- All outputs are combinational decodes of the registered state, plus mem_ready where noted. Outputs not listed as asserted in a state are 0; mem_size defaults to 10.
- Reset (rst=0): state=FETCH, wait counter=0. Outputs take the FETCH decode with mem_ready gating. Reset mid-instruction aborts it: no reg_write, mem_write or PC update occurs after rst falls.

State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, TRAP=12.

Per-state outputs and transitions:
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready, else stays.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw/lb/lh/sw/sb/sh → MEM_ADDR
  - 000000 → EXEC_R
  - addi/andi/ori/slti → EXEC_I
  - beq/bne/bgtz → BRANCH
  - j/jal → JUMP
  - other → TRAP (TRAP_EN=1) or FETCH with instr_done=1 (TRAP_EN=0)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Loads → MEM_RD; stores → MEM_WR.
- MEM_RD: mem_read=1, iord=1, mem_size by opcode (lb 00, lh 01, lw 10). Goes to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=00, instr_done=1. → FETCH.
- MEM_WR: mem_write=1, iord=1, mem_size by opcode; instr_done=mem_ready. Goes to FETCH on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. → R_WB.
- R_WB: reg_write=1, reg_dst=01, instr_done=1. → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11. → I_WB.
- I_WB: reg_write=1, reg_dst=00, instr_done=1. → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, branch_type by opcode, instr_done=1. → FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. jal additionally asserts reg_write=1, reg_dst=10, mem_to_reg=0 (PC link). → FETCH.
- TRAP: trap=1, pc_write=1, pc_src=11, instr_done=0. → FETCH.

Wait timeout:
- An 8-bit counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0 in those states.
- When the counter reaches TIMEOUT_CYC with mem_ready still 0, the next state is TRAP (TRAP_EN=1 and MEM_WAIT_EN=1).
- If mem_ready=1 arrives in the same cycle the limit is hit, the access completes normally; ready wins.

Latency with zero wait states: lw 5 cycles, sw/R/I 4, branch/jump 3, trap 3 (FETCH, DECODE, TRAP).

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum/localparams;
  - opcode constants (LW, LB, LH, SW, SB, SH, ADDI, ANDI, ORI, SLTI, RTYPE, BEQ, BNE, BGTZ, J, JAL);
  - alu_op, pc_src, reg_dst and mem_size codes.
- Sub-module mips_ctrl_wait_timer contains the wait counter and exposes a timeout flag.

Test Plan:
- lw (0x8C820004), mem_ready=1 always → state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done at cycle 5.
- sb (0xA0A20000), mem_ready low 3 cycles in MEM_WR → mem_write=1 and mem_size=00 held 4 cycles; instr_done coincides with mem_ready.
- beq (0x10220003) → pc_write_cond=1, branch_type=00, pc_src=01, alu_op=01 in cycle 3; back to FETCH.
- jal (0x0C000010) → JUMP: pc_write=1, pc_src=10, reg_write=1, reg_dst=10.
- Opcode 0x3F with TRAP_EN=1 → TRAP: trap=1, pc_src=11. Repeat with TRAP_EN=0 → FETCH after DECODE, trap stays 0.
- FETCH with mem_ready=0 for 16 cycles (TIMEOUT_CYC=15) → TRAP. Separately, assert rst=0 in MEM_WR → state=0 immediately and mem_write=0.
